// File: rtl/led_disp_pkg.sv
// Shared definitions for the press-count LED display: BCD digit type and
// active-low common-anode segment patterns, bit order {dp,g,f,e,d,c,b,a}.
package led_disp_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank.
module seg7_decoder
    import led_disp_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [7:0]  seg
);

    // Look up the segment pattern for the digit, blanking anything above 9
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/press_count_display.sv
// Counts rising edges of a debounced key level as a two-digit BCD value and
// multiplexes it onto a two-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is 0.
module press_count_display
    import led_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       counter_en,
    input  logic       clr,
    output logic [7:0] count_bcd,
    output logic [1:0] an,
    output logic [7:0] seg
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    logic        counter_en_d_q, counter_en_d_d;
    logic        armed_q, armed_d;
    logic        press_pulse_q, press_pulse_d;
    bcd_digit_t  ones_q, ones_d;
    bcd_digit_t  tens_q, tens_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic        sel_q, sel_d;
    logic [1:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    bcd_digit_t  digit_mux;
    logic [7:0]  dec_seg;

    // Single decoder shared by both digits; the scan select picks its input
    seg7_decoder u_seg7_decoder (
        .digit (digit_mux),
        .seg   (dec_seg)
    );

    // Next-state logic for edge detect, BCD counter, scan timer and display
    always_comb begin
        counter_en_d_d = counter_en;
        // armed_q is low only for the first edge after reset, so a key already
        // held through reset is absorbed into counter_en_d instead of counting
        armed_d        = 1'b1;
        press_pulse_d  = counter_en & ~counter_en_d_q & armed_q;

        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (press_pulse_q) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        scan_cnt_d = scan_cnt_q + 16'd1;
        sel_d      = sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = 16'd0;
            sel_d      = ~sel_q;
        end

        digit_mux = sel_q ? tens_q : ones_q;
        an_d      = sel_q ? 2'b01 : 2'b10;
        seg_d     = dec_seg | 8'h80;
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_q && (tens_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`else
`endif
    end

    // State registers; reset leaves the display dark with both digits off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_en_d_q <= 1'b0;
            armed_q        <= 1'b0;
            press_pulse_q  <= 1'b0;
            ones_q         <= 4'd0;
            tens_q         <= 4'd0;
            scan_cnt_q     <= 16'd0;
            sel_q          <= 1'b0;
            an_q           <= 2'b11;
            seg_q          <= SEG_BLANK;
        end else begin
            counter_en_d_q <= counter_en_d_d;
            armed_q        <= armed_d;
            press_pulse_q  <= press_pulse_d;
            ones_q         <= ones_d;
            tens_q         <= tens_d;
            scan_cnt_q     <= scan_cnt_d;
            sel_q          <= sel_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
        end
    end

    assign count_bcd = {tens_q, ones_q};
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_press_count_display.sv
// Directed bench for press_count_display with SCAN_DIV=4. Expected counts are
// pushed to a queue when a press is driven and popped when the count updates.
// Honours LEADING_ZERO_BLANK_EN to pick the expected blank/zero tens pattern.
module tb_press_count_display;

    logic       clk;
    logic       rst_n;
    logic       counter_en;
    logic       clr;
    logic [7:0] count_bcd;
    logic [1:0] an;
    logic [7:0] seg;

    int         checks = 0;
    int         errors = 0;
    int         exp_val = 0;
    logic [7:0] exp_q[$];

    press_count_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .counter_en (counter_en),
        .clr        (clr),
        .count_bcd  (count_bcd),
        .an         (an),
        .seg        (seg)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] toBcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic popCompare(input string tag);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, count_bcd, 8'hXX);
        end else begin
            checkOutput(tag, count_bcd, exp_q.pop_front());
        end
    endtask

    // Wait (bounded) at negedges until the given digit enable is active
    task automatic waitSlot(input logic [1:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((an !== target) && (n < 12));
        checkOutput("slot_reach", {6'b0, an}, {6'b0, target});
    endtask

    // One short key press: rise, count two edges later, then release
    task automatic applyStimulus();
        @(negedge clk);
        counter_en = 1'b1;
        exp_val = (exp_val + 1) % 100;
        exp_q.push_back(toBcd(exp_val));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        popCompare("press_count");
        counter_en = 1'b0;
    endtask

    initial begin
        logic [1:0] first_an;
        logic [1:0] prev_an;
        int n;

        rst_n      = 1'b0;
        counter_en = 1'b0;
        clr        = 1'b0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        checkOutput("reset_count", count_bcd, 8'h00);
        checkOutput("reset_an", {6'b0, an}, 8'h03);
        checkOutput("reset_seg", seg, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_an", {6'b0, an}, 8'h02);
        checkOutput("post_reset_seg", seg, 8'hC0);

        // Single press held for 20 cycles counts exactly once
        @(negedge clk);
        counter_en = 1'b1;
        exp_val = 1;
        exp_q.push_back(toBcd(exp_val));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        popCompare("single_press");
        repeat (18) @(negedge clk);
        checkOutput("held_no_repeat", count_bcd, 8'h01);
        counter_en = 1'b0;
        waitSlot(2'b10);
        checkOutput("ones_slot_1", seg, 8'hF9);

        // Nine more presses carry into the tens digit
        repeat (9) applyStimulus();
        checkOutput("count_10", count_bcd, 8'h10);
        waitSlot(2'b01);
        checkOutput("tens_slot_1", seg, 8'hF9);
        waitSlot(2'b10);
        checkOutput("ones_slot_0", seg, 8'hC0);

        // Climb to 37, then clear in the same cycle as the press pulse
        repeat (27) applyStimulus();
        checkOutput("count_37", count_bcd, 8'h37);
        @(negedge clk);
        counter_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        exp_val = 0;
        exp_q.push_back(8'h00);
        @(posedge clk);
        @(negedge clk);
        popCompare("clr_priority");
        clr = 1'b0;
        counter_en = 1'b0;
        @(negedge clk);
        checkOutput("clr_no_late_inc", count_bcd, 8'h00);

        // Build variant: tens digit at count 05
        repeat (5) applyStimulus();
        checkOutput("count_05", count_bcd, 8'h05);
        waitSlot(2'b01);
        checkOutput("tens_slot_an", {6'b0, an}, 8'h01);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("tens_zero_blank", seg, 8'hFF);
`else
        checkOutput("tens_zero_shown", seg, 8'hC0);
`endif

        // Reset mid-press; key still held at release must not count
        @(negedge clk);
        counter_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midpress_reset_count", count_bcd, 8'h00);
        rst_n = 1'b1;
        exp_val = 0;
        repeat (6) @(negedge clk);
        checkOutput("midpress_no_pulse", count_bcd, 8'h00);
        counter_en = 1'b0;
        @(negedge clk);

        // Scan: digit enable alternates every 4 cycles, never both on
        prev_an = an;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((an === prev_an) && (n < 12));
        checkOutput("scan_align", {7'b0, an !== prev_an}, 8'h01);
        first_an = an;
        for (int i = 0; i < 16; i++) begin
            checkOutput("scan_an", {6'b0, an}, {6'b0, ((i / 4) % 2 == 0) ? first_an : ~first_an});
            checkOutput("scan_not_both", {7'b0, an === 2'b00}, 8'h00);
            @(negedge clk);
        end

        // Wrap: 99 presses reach 99, the 100th returns to 00
        repeat (99) applyStimulus();
        checkOutput("count_99", count_bcd, 8'h99);
        applyStimulus();
        checkOutput("wrap_00", count_bcd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_count_display.md
PRESS_COUNT_DISPLAY -- requirements
Module: press_count_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is displayed per scan slot; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port counter_en  input  1  debounced key level from the debounce stage; high while the key is held.
REQ-005 SHALL have port clr  input  1  synchronous clear of the press count, active-high.
REQ-006 SHALL have port count_bcd  output  8  registered press count, {tens[3:0], ones[3:0]} in BCD.
REQ-007 SHALL have port an  output  2  registered digit enables, active-low; an[0] is the ones digit, an[1] is the tens digit.
REQ-008 SHALL have port seg  output  8  registered segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-009 SHALL register counter_en into counter_en_d every cycle.
REQ-010 SHALL register press_pulse <= counter_en & ~counter_en_d, giving one cycle of high per rising edge of counter_en.
REQ-011 SHALL keep press_pulse low while counter_en is held high or is low.
REQ-012 SHALL increment count_bcd by 1 BCD at the edge after press_pulse is high: a press-pulse sampled high at edge N updates count_bcd at edge N+1.
REQ-013 SHALL carry ones 9 -> 0 into tens, and SHALL wrap count 99 -> 00.
REQ-014 SHALL give clr priority over an increment in the same cycle; count_bcd becomes 00 at the next edge.
REQ-015 SHALL run a scan counter 0..SCAN_DIV-1; at the terminal count it returns to 0 and toggles digit select sel.
REQ-016 SHALL select digits as: sel=0 gives an=2'b10 and seg=ones pattern; sel=1 gives an=2'b01 and seg=tens pattern.
REQ-017 SHALL register an and seg from the current sel and count_bcd, so the display reflects count_bcd one cycle after it changes, within the active slot.
REQ-018 SHALL hold dp (seg[7]) at 1 (off) at all times.
REQ-019 SHALL use the standard common-anode 7-segment patterns for digits 0-9: 0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8, 8=8'h80, 9=8'h90.
REQ-020 SHALL never drive both an bits low in the same cycle.

Reset
REQ-021 SHALL, while rst_n=0, force: count_bcd=8'h00, counter_en_d=0, press_pulse=0, scan counter=0, sel=0, an=2'b11, seg=8'hFF.
REQ-022 SHALL resume after rst_n deasserts, showing an=2'b10 and seg=8'hC0 after the first clock edge.
REQ-023 SHALL discard a press in progress when reset is asserted mid-press; a level already high at release produces no pulse, since counter_en_d reloads it.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is defined, drive seg=8'hFF during the tens slot if tens=0 while an still follows REQ-016; when undefined, tens=0 shows 8'hC0.

Structure
REQ-026 SHALL place the 7-segment pattern constants, the blank constant 8'hFF, and the BCD digit typedef (4-bit) in shared package led_disp_pkg.
REQ-027 SHALL implement the digit-to-segment conversion as a combinational sub-module seg7_decoder (4-bit in, 8-bit out; values 10-15 give 8'hFF), instantiated once on the muxed digit.

Verification (SCAN_DIV=4 in bench)
REQ-028 SHALL verify reset: hold rst_n=0 for 3 cycles -> count_bcd=00, an=11, seg=FF; after release, first edge gives an=10, seg=C0.
REQ-029 SHALL verify single press: counter_en 0->1 held 20 cycles -> exactly one press_pulse, and count_bcd=01 two edges after the rise; seg=F9 in the ones slot.
REQ-030 SHALL verify wrap: 100 presses -> count_bcd=00 after the last; after 10 presses, count_bcd=8'h10, and the tens slot shows F9 while the ones slot shows C0.
REQ-031 SHALL verify clear priority: assert clr in the same cycle as press_pulse with count 8'h37 -> count_bcd=00 next edge, with no increment.
REQ-032 SHALL verify scanning: observe 16 cycles -> an alternates 10/01 every 4 cycles and is never 00.
REQ-033 SHALL verify the build variant: build with LEADING_ZERO_BLANK_EN at count 8'h05 -> tens slot shows seg=FF and an=01; build without the macro -> tens slot shows seg=C0.
